onebit_sdr_decim: RTL and testbench
===================================

ONEBIT_SDR_DECIM -- requirements
Module: onebit_sdr_decim

Interface
REQ-001 SHALL have parameter NUM_CH, default 1, number of 1-bit RF input channels (legal 1..4).
REQ-002 SHALL have parameter MAX_DEC_LOG2, default 12, largest decimation exponent (legal 2..12).
REQ-003 SHALL have port clk_data  input  1  sampling clock; sole clock of the block.
REQ-004 SHALL have port rst  input  1  reset, synchronous to clk_data, active-high.
REQ-005 SHALL have port enable  input  1  accumulation enable.
REQ-006 SHALL have port dec_log2  input  4  decimation exponent k; period = 2^k samples; values outside 2..MAX_DEC_LOG2 are clamped to the nearest legal value.
REQ-007 SHALL have port signed_mode  input  1  0 = unsigned count, 1 = count minus 2^(k-1), two's complement.
REQ-008 SHALL have port rf_in  input  NUM_CH  comparator bits, bit i = channel i.
REQ-009 SHALL have port out_data  output  16  sample word: [15:14] channel id, [13] drop flag, [12:0] value.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_ready  input  1  downstream (FIFO write side) accepts word.
REQ-012 SHALL have port drop_count  output  16  saturating count of dropped frames.

Function
REQ-013 SHALL hold a period counter that advances one per clk_data cycle while enable=1 and wraps after 2^k cycles.
REQ-014 SHALL latch k from dec_log2/signed_mode only when the period counter is 0; mid-period changes take effect at the next period start.
REQ-015 SHALL, per channel, sum rf_in[i] over exactly the 2^k cycles of one period, including the final-cycle bit; value range 0..2^k in 13 bits.
REQ-016 SHALL restart each accumulator at zero for the next period with no lost sample cycle between periods.
REQ-017 SHALL, when signed_mode=1, output value = sum - 2^(k-1), sign-extended to 13 bits (range -2^(k-1)..+2^(k-1)).
REQ-018 SHALL, on the final period cycle, copy all NUM_CH results into a holding bank (one frame).
REQ-019 SHALL run an emitter FSM with states IDLE and EMIT(ch); IDLE->EMIT(0) when a frame is banked; EMIT(ch)->EMIT(ch+1) on out_valid&out_ready; EMIT(NUM_CH-1)->IDLE on handshake.
REQ-020 SHALL assert out_valid in EMIT only, first word in the cycle after the final period cycle.
REQ-021 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-022 SHALL declare a drop when a new frame completes while EMIT is active and the last-channel handshake is not occurring in that same cycle; the new frame is discarded, the in-flight frame is untouched.
REQ-023 SHALL treat frame completion coincident with last-channel handshake as no drop; the new frame loads and EMIT(0) follows directly.
REQ-024 SHALL increment drop_count per drop, saturating at 0xFFFF.
REQ-025 SHALL set bit 13 on channel 0 of the first frame emitted after any drop, then clear it.
REQ-026 SHALL, when enable falls, clear period counter and accumulators, discard the partial period, and let the emitter finish any banked frame.

Reset
REQ-027 SHALL on rst=1: out_valid=0, out_data=0, drop_count=0, FSM=IDLE, counter/accumulators/bank/drop flag cleared, latched k=2, signed_mode=0.
REQ-028 SHALL abandon any in-flight frame on rst mid-EMIT without completing handshakes.

Structure
REQ-029 SHALL place word field positions, CH_ID_W, VALUE_W=13 and the emitter state encoding in package onebit_sdr_pkg.
REQ-030 SHALL implement the per-channel counter/accumulator as sub-module onebit_accum, instantiated NUM_CH times.

Verification
REQ-031 NUM_CH=1, k=2, unsigned, rf_in=1 constant, out_ready=1 -> one word every 4 cycles, value 4, id 0.
REQ-032 NUM_CH=4, k=3, signed, rf_in=4'b0101 constant -> words ids 0..3 in order, values +4,-4,+4,-4, per 8-cycle period.
REQ-033 NUM_CH=2, k=2, out_ready=0 for 12 cycles -> drop_count=2, first subsequent frame ch0 bit13=1, ch1 bit13=0.
REQ-034 dec_log2 changed 4->2 at mid-period -> current period 16 cycles, next 4 cycles; dec_log2=15 -> behaves as 12.
REQ-035 NUM_CH=4, k=2, out_ready=1 -> last-channel handshake coincides with frame completion, drop_count stays 0, continuous valid.
REQ-036 rst asserted mid-EMIT -> next cycle out_valid=0, drop_count=0; enable toggled mid-period -> partial sum never emitted.

Source files
------------

// File: rtl/onebit_sdr_pkg.sv
// Shared constants, output word layout and emitter state encoding for the
// 1-bit SDR decimator.
package onebit_sdr_pkg;

  localparam int unsigned CH_ID_W  = 2;
  localparam int unsigned VALUE_W  = 13;
  localparam int unsigned WORD_W   = 16;

  // Output word field positions
  localparam int unsigned ID_MSB   = 15;
  localparam int unsigned ID_LSB   = 14;
  localparam int unsigned DROP_BIT = 13;
  localparam int unsigned VAL_MSB  = 12;

  localparam int unsigned MIN_DEC_LOG2 = 2;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } emit_state_e;

  // Clamp a requested decimation exponent into MIN_DEC_LOG2..hi
  function automatic logic [3:0] clamp_k(input logic [3:0] d, input int unsigned hi);
    int unsigned dv;
    dv = 32'(d);
    if (dv < MIN_DEC_LOG2) return 4'(MIN_DEC_LOG2);
    if (dv > hi)           return 4'(hi);
    return d;
  endfunction

endpackage

// File: rtl/onebit_accum.sv
// Per-channel ones counter over one decimation period, with optional
// offset to a two's-complement result centred on zero.
module onebit_accum
  import onebit_sdr_pkg::*;
(
  input  logic               clk_data,
  input  logic               rst,
  input  logic               enable,
  input  logic               rf_bit,
  input  logic               period_last,
  input  logic               signed_mode,
  input  logic [3:0]         k,
  output logic [VALUE_W-1:0] value
);

  logic [VALUE_W-1:0] acc_q, acc_d;
  logic [VALUE_W-1:0] sum;

  // Running sum; the final-cycle bit is folded into the result directly
  always_comb begin
    sum   = acc_q + VALUE_W'(rf_bit);
    acc_d = acc_q;
    if (!enable || period_last) acc_d = '0;
    else                        acc_d = sum;
    value = sum;
    if (signed_mode) value = sum - (VALUE_W'(1) << (k - 4'd1));
  end

  // Accumulator register
  always_ff @(posedge clk_data) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/onebit_sdr_decim.sv
// Multi-channel 1-bit decimator: shared period counter, per-channel
// accumulators, a one-frame holding bank and a valid/ready word emitter.
module onebit_sdr_decim
  import onebit_sdr_pkg::*;
#(
  parameter int unsigned NUM_CH       = 1,
  parameter int unsigned MAX_DEC_LOG2 = 12
) (
  input  logic              clk_data,
  input  logic              rst,
  input  logic              enable,
  input  logic [3:0]        dec_log2,
  input  logic              signed_mode,
  input  logic [NUM_CH-1:0] rf_in,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       drop_count
);

  localparam int unsigned   CW      = MAX_DEC_LOG2;
  localparam logic [CW-1:0] ONES    = '1;
  localparam logic [CH_ID_W-1:0] LAST_CH = CH_ID_W'(NUM_CH - 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         k_q, k_d, k_eff;
  logic               sgn_q, sgn_d, sgn_eff;
  logic               period_last;

  emit_state_e        state_q, state_d;
  logic [CH_ID_W-1:0] ch_q, ch_d;
  logic [VALUE_W-1:0] bank_q [NUM_CH];
  logic [VALUE_W-1:0] bank_d [NUM_CH];
  logic [VALUE_W-1:0] acc_val [NUM_CH];
  logic               flag_q, flag_d;
  logic               pend_q, pend_d;
  logic [15:0]        drop_q, drop_d;
  logic               hs, last_hs;
  logic [VALUE_W-1:0] sel_val;

  // Period counter; the config is taken live at count 0 so a new k governs
  // the very period that starts on that cycle, and held for the rest of it
  always_comb begin
    k_eff       = (cnt_q == '0) ? clamp_k(dec_log2, MAX_DEC_LOG2) : k_q;
    sgn_eff     = (cnt_q == '0) ? signed_mode : sgn_q;
    k_d         = k_eff;
    sgn_d       = sgn_eff;
    period_last = enable && (cnt_q == ~(ONES << k_eff));
    cnt_d       = cnt_q + CW'(1);
    if (!enable || period_last) cnt_d = '0;
  end

  // Counter and latched configuration registers
  always_ff @(posedge clk_data) begin
    if (rst) begin
      cnt_q <= '0;
      k_q   <= 4'(MIN_DEC_LOG2);
      sgn_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      k_q   <= k_d;
      sgn_q <= sgn_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_acc
    onebit_accum u_acc (
      .clk_data    (clk_data),
      .rst         (rst),
      .enable      (enable),
      .rf_bit      (rf_in[g]),
      .period_last (period_last),
      .signed_mode (sgn_eff),
      .k           (k_eff),
      .value       (acc_val[g])
    );
  end

  // Emitter next state: handshake advance, then frame load or drop
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    bank_d  = bank_q;
    flag_d  = flag_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    hs      = out_valid && out_ready;
    last_hs = hs && (ch_q == LAST_CH);
    if (hs) begin
      if (last_hs) begin
        state_d = ST_IDLE;
        ch_d    = '0;
      end else begin
        ch_d = ch_q + CH_ID_W'(1);
      end
    end
    if (period_last) begin
      if (state_q == ST_IDLE || last_hs) begin
        bank_d  = acc_val;
        state_d = ST_EMIT;
        ch_d    = '0;
        flag_d  = pend_q;
        pend_d  = 1'b0;
      end else begin
        pend_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  // Emitter registers
  always_ff @(posedge clk_data) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      flag_q  <= 1'b0;
      pend_q  <= 1'b0;
      drop_q  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      flag_q  <= flag_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      bank_q  <= bank_d;
    end
  end

  // Output word assembly from the bank entry of the current channel
  always_comb begin
    sel_val = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      if (ch_q == CH_ID_W'(i)) sel_val = bank_q[i];
    out_valid = (state_q == ST_EMIT);
    out_data  = '0;
    if (out_valid) begin
      out_data[ID_MSB:ID_LSB] = ch_q;
      out_data[DROP_BIT]      = flag_q && (ch_q == '0);
      out_data[VAL_MSB:0]     = sel_val;
    end
    drop_count = drop_q;
  end

endmodule

// File: tb/tb_onebit_sdr_decim.sv
// Directed bench for onebit_sdr_decim: three instances (1, 2 and 4 channels)
// share control inputs; expected words are hand-computed constants.
module tb_onebit_sdr_decim;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  dec_log2 = 4'd2;
  logic        signed_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic        rf1 = 1'b0;
  logic [1:0]  rf2 = '0;
  logic [3:0]  rf4 = '0;

  logic [15:0] d1, d2, d4, dc1, dc2, dc4;
  logic        v1, v2, v4;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  onebit_sdr_decim #(.NUM_CH(1), .MAX_DEC_LOG2(12)) u1 (
    .clk_data(clk), .rst(rst), .enable(enable), .dec_log2(dec_log2),
    .signed_mode(signed_mode), .rf_in(rf1), .out_data(d1), .out_valid(v1),
    .out_ready(out_ready), .drop_count(dc1));

  onebit_sdr_decim #(.NUM_CH(2), .MAX_DEC_LOG2(12)) u2 (
    .clk_data(clk), .rst(rst), .enable(enable), .dec_log2(dec_log2),
    .signed_mode(signed_mode), .rf_in(rf2), .out_data(d2), .out_valid(v2),
    .out_ready(out_ready), .drop_count(dc2));

  onebit_sdr_decim #(.NUM_CH(4), .MAX_DEC_LOG2(12)) u4 (
    .clk_data(clk), .rst(rst), .enable(enable), .dec_log2(dec_log2),
    .signed_mode(signed_mode), .rf_in(rf4), .out_data(d4), .out_valid(v4),
    .out_ready(out_ready), .drop_count(dc4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_v1", 32'(v1), 0);  chk("rst_d1", 32'(d1), 0);  chk("rst_dc1", 32'(dc1), 0);
    chk("rst_v4", 32'(v4), 0);  chk("rst_d4", 32'(d4), 0);  chk("rst_dc4", 32'(dc4), 0);

    // 1 channel, k=2, unsigned, constant ones: word 0x0004 every 4 cycles
    dec_log2 = 4'd2; signed_mode = 1'b0; out_ready = 1'b1; rf1 = 1'b1;
    enable = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk($sformatf("t1_v%0d", n), 32'(v1), (n % 4 == 0) ? 1 : 0);
      if (v1) chk($sformatf("t1_d%0d", n), 32'(d1), 32'h0004);
    end

    // 4 channels, k=3, signed, 0101: +4,-4,+4,-4 with ids 0..3
    do_reset();
    dec_log2 = 4'd3; signed_mode = 1'b1; rf4 = 4'b0101;
    enable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      case (n)
        8, 16:  chk($sformatf("t2_d%0d", n), 32'(d4), 32'h0004);
        9, 17:  chk($sformatf("t2_d%0d", n), 32'(d4), 32'h5FFC);
        10, 18: chk($sformatf("t2_d%0d", n), 32'(d4), 32'h8004);
        11, 19: chk($sformatf("t2_d%0d", n), 32'(d4), 32'hDFFC);
        12, 7:  chk($sformatf("t2_v%0d", n), 32'(v4), 0);
        default: ;
      endcase
    end

    // 2 channels, k=2, ready low for 12 cycles: two drops, flag on next frame
    do_reset();
    dec_log2 = 4'd2; signed_mode = 1'b0; rf2 = 2'b01; out_ready = 1'b0;
    enable = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 4 || n == 11) chk($sformatf("t3_hold%0d", n), 32'(d2), 32'h0004);
    end
    chk("t3_drops", 32'(dc2), 2);
    out_ready = 1'b1;
    for (int n = 13; n <= 20; n++) begin
      tick();
      case (n)
        13: chk("t3_old_ch1", 32'(d2), 32'h4000);
        14: chk("t3_idle", 32'(v2), 0);
        16: chk("t3_flag_ch0", 32'(d2), 32'h2004);
        17: chk("t3_ch1", 32'(d2), 32'h4000);
        20: chk("t3_flag_clr", 32'(d2), 32'h0004);
        default: ;
      endcase
    end
    chk("t3_drops_end", 32'(dc2), 2);

    // k changed 4->2 mid-period: 16-cycle period then 4-cycle period
    do_reset();
    dec_log2 = 4'd4; signed_mode = 1'b0; rf1 = 1'b1;
    enable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 8) dec_log2 = 4'd2;
      case (n)
        4, 15, 19: chk($sformatf("t4_v%0d", n), 32'(v1), 0);
        16: chk("t4_d16", 32'(d1), 32'h0010);
        20: chk("t4_d20", 32'(d1), 32'h0004);
        default: ;
      endcase
    end

    // dec_log2=15 clamps to 12: 4096-cycle period, value 4096
    do_reset();
    dec_log2 = 4'd15;
    enable = 1'b1;
    for (int n = 1; n <= 4096; n++) begin
      tick();
      if (n == 4095) chk("t5_v4095", 32'(v1), 0);
      if (n == 4096) chk("t5_d4096", 32'(d1), 32'h1000);
    end

    // dec_log2=0 clamps to 2
    do_reset();
    dec_log2 = 4'd0;
    enable = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (n == 3) chk("t6_v3", 32'(v1), 0);
      if (n == 4) chk("t6_d4", 32'(d1), 32'h0004);
    end

    // 4 channels, k=2, ready high: back-to-back frames, no drops
    do_reset();
    dec_log2 = 4'd2; rf4 = 4'b1111; out_ready = 1'b1;
    enable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n >= 4)
        chk($sformatf("t7_d%0d", n), 32'(d4), {16'h0, 2'((n - 4) % 4), 14'h0004});
    end
    chk("t7_drops", 32'(dc4), 0);

    // rst mid-EMIT abandons the frame and clears drop_count
    do_reset();
    dec_log2 = 4'd2; rf2 = 2'b01; out_ready = 1'b0;
    enable = 1'b1;
    for (int n = 1; n <= 9; n++) tick();
    chk("t8_pre_drop", 32'(dc2), 1);
    rst = 1'b1;
    tick();
    chk("t8_v", 32'(v2), 0);
    chk("t8_dc", 32'(dc2), 0);
    chk("t8_d", 32'(d2), 0);

    // enable toggled mid-period: partial sum discarded, full period follows
    do_reset();
    dec_log2 = 4'd2; rf1 = 1'b1; out_ready = 1'b1;
    enable = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 2) enable = 1'b0;
      if (n == 3) enable = 1'b1;
      if (n < 7) chk($sformatf("t9_v%0d", n), 32'(v1), 0);
      else       chk("t9_d7", 32'(d1), 32'h0004);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
